// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB arbiter slice.
// Holds the FSM state encoding, the requester count and the UART register map.
package uart_apb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // UART slave register offsets
  localparam logic [31:0] TXRX      = 32'd0;
  localparam logic [31:0] BRD       = 32'd1;
  localparam logic [31:0] PRESCALE  = 32'd2;
  localparam logic [31:0] UARTCTRL  = 32'd3;
  localparam logic [31:0] UARTFLAGS = 32'd4;

  // Requester index to one-hot response/accept vector
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: one-hot grant from the valid vector, and the
// last-granted pointer advances only when the grant is actually taken.
module rr_arb2
  import uart_apb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // Last granted requester; reset value 1 makes requester 0 win first
  logic last_q;

  // Contention goes to the requester that was not granted last; a lone valid always wins
  always_comb begin
    // NOTE: default assignment first so no path leaves grant_o unassigned (no latch).
    grant_o = '0;
    if (valid_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
    else                  grant_o = valid_i;
  end

  // Remember the winner whenever a grant is consumed
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst)                     last_q <= 1'b1;
    else if (en_i && |valid_i)   last_q <= grant_o[1];
  end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Arbitrates two command requesters onto a single APB master port to a UART.
// IDLE grants and latches a command, SETUP/ACCESS run the APB transfer,
// RESP returns data/error to the granted requester.
// Optional feature: define UART_APB_ARB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait cycles with an error response.
module uart_apb_arbiter
  import uart_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_WRITE,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  input  logic [7:0]  REQ_STRB,
  output logic [1:0]  REQ_ACCEPT,
  output logic [1:0]  RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        BUSY
);

  // Legal timeout range is 1..255 (8-bit wait counter)
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("uart_apb_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  state_e      state_q;
  logic        sel_q;        // granted requester index
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  grant;
  logic        idle;
  logic        write_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  strb_d;

  assign idle = (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk     (PCLK),
    .rst     (PRESET),
    .valid_i (REQ_VALID),
    .en_i    (idle),
    .grant_o (grant)
  );

  // Select the granted requester's command; reads carry zero data and strobes
  always_comb begin
    write_d = grant[1] ? REQ_WRITE[1]      : REQ_WRITE[0];
    addr_d  = grant[1] ? REQ_ADDR[63:32]   : REQ_ADDR[31:0];
    wdata_d = grant[1] ? REQ_WDATA[63:32]  : REQ_WDATA[31:0];
    strb_d  = grant[1] ? REQ_STRB[7:4]     : REQ_STRB[3:0];
    if (!write_d) begin
      wdata_d = '0;
      strb_d  = '0;
    end
  end

`ifdef UART_APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_q;
`endif

  // Transfer FSM: grant/latch, APB setup and access phases, one-cycle response
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef UART_APB_ARB_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            sel_q   <= grant[1];
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
`ifdef UART_APB_ARB_TIMEOUT_EN
          wait_q  <= '0;
`endif
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            rdata_q <= write_q ? 32'd0 : PRDATA;
            err_q   <= PSLVERR;
            state_q <= ST_RESP;
          end
`ifdef UART_APB_ARB_TIMEOUT_EN
          else if (wait_q + 8'd1 == TIMEOUT_LIMIT) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end else if (wait_q != 8'hFF) begin
            wait_q  <= wait_q + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic apb_phase;
  logic resp;
  assign apb_phase = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign resp      = (state_q == ST_RESP);

  assign BUSY       = !idle;
  assign REQ_ACCEPT = (idle && !PRESET) ? grant : 2'b00;
  assign PSEL       = apb_phase;
  assign PENABLE    = (state_q == ST_ACCESS);
  assign PWRITE     = apb_phase && write_q;
  assign PADDR      = apb_phase ? addr_q  : 32'd0;
  assign PWDATA     = apb_phase ? wdata_q : 32'd0;
  assign PSTRB      = apb_phase ? strb_q  : 4'd0;
  assign RSP_VALID  = resp ? req_onehot(sel_q) : 2'b00;
  assign RSP_RDATA  = resp ? rdata_q : 32'd0;
  assign RSP_ERR    = resp && err_q;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Directed bench for uart_apb_arbiter with a response scoreboard.
module tb_uart_apb_arbiter;

`ifdef UART_APB_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        PCLK, PRESET;
  logic [1:0]  REQ_VALID, REQ_WRITE;
  logic [63:0] REQ_ADDR, REQ_WDATA;
  logic [7:0]  REQ_STRB;
  logic [1:0]  REQ_ACCEPT, RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR, BUSY;

  uart_apb_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB), .REQ_ACCEPT(REQ_ACCEPT),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .BUSY(BUSY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  vec;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int req, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.vec   = (req == 1) ? 2'b10 : 2'b01;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic set_cmd(input int req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    REQ_WRITE[req]          = wr;
    REQ_ADDR[req*32 +: 32]  = addr;
    REQ_WDATA[req*32 +: 32] = wdata;
    REQ_STRB[req*4 +: 4]    = strb;
  endtask

  // Compare the current response cycle against the oldest expectation
  task automatic sb_compare(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'(e.vec));
      check({tag, "_rsp_rdata"}, 64'(RSP_RDATA), 64'(e.rdata));
      check({tag, "_rsp_err"},   64'(RSP_ERR),   64'(e.err));
    end
  endtask

  task automatic wait_accept(input string tag, input logic [1:0] exp_v);
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (REQ_ACCEPT != 2'b00) break;
    end
    check(tag, 64'(REQ_ACCEPT), 64'(exp_v));
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (RSP_VALID != 2'b00) break;
    end
    sb_compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0;
    REQ_WDATA = '0; REQ_STRB = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;

    // Reset state
    repeat (2) @(negedge PCLK);
    check("rst_busy",   64'(BUSY), 64'd0);
    check("rst_apb",    64'({PSEL, PENABLE, PWRITE}), 64'd0);
    check("rst_paddr",  64'(PADDR), 64'd0);
    check("rst_rsp",    64'({RSP_VALID, RSP_ERR}), 64'd0);
    check("rst_accept", 64'(REQ_ACCEPT), 64'd0);
    @(posedge PCLK); #1 PRESET = 1'b0;

    // Both requesters continuously valid: alternating grants 0,1,0,1
    set_cmd(0, 1'b0, 32'd4, 32'd0, 4'd0);
    set_cmd(1, 1'b0, 32'd4, 32'd0, 4'd0);
    REQ_VALID = 2'b11;
    for (int k = 0; k < 4; k++) begin
      PRDATA = 32'h1000 + 32'(k * 17);
      wait_accept("rr_accept", (k % 2 == 1) ? 2'b10 : 2'b01);
      push_exp(k % 2, 32'h1000 + 32'(k * 17), 1'b0);
      wait_rsp("rr");
    end
    @(posedge PCLK); #1 REQ_VALID = 2'b00;

    // Requester 0 write, minimum latency
    set_cmd(0, 1'b1, 32'd0, 32'h41, 4'b0001);
    PRDATA = 32'hDEAD_BEEF;
    REQ_VALID = 2'b01;
    wait_accept("wr0_accept", 2'b01);
    push_exp(0, 32'd0, 1'b0);
    @(posedge PCLK); #1 REQ_VALID = 2'b00;
    @(negedge PCLK);
    check("wr0_setup_ctl", 64'({PSEL, PENABLE, PWRITE, BUSY}), 64'b1011);
    check("wr0_paddr",     64'(PADDR), 64'd0);
    check("wr0_pwdata",    64'(PWDATA), 64'h41);
    check("wr0_pstrb",     64'(PSTRB), 64'b0001);
    @(negedge PCLK);
    check("wr0_access_ctl", 64'({PSEL, PENABLE}), 64'b11);
    check("wr0_access_wd",  64'(PWDATA), 64'h41);
    @(negedge PCLK);
    sb_compare("wr0");
    check("wr0_psel_off", 64'(PSEL), 64'd0);

    // Requester 1 read with five wait states
    @(posedge PCLK); #1;
    PREADY = 1'b0; PRDATA = 32'h5A;
    set_cmd(1, 1'b0, 32'd0, 32'hFFFF_FFFF, 4'hF);
    REQ_VALID = 2'b10;
    wait_accept("rd1_accept", 2'b10);
    push_exp(1, 32'h5A, 1'b0);
    @(posedge PCLK); #1 REQ_VALID = 2'b00;
    @(negedge PCLK);
    check("rd1_setup_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'b100);
    check("rd1_setup_wd",  64'({PWDATA, PSTRB}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      check("rd1_access", 64'({PSEL, PENABLE, BUSY}), 64'b111);
      if (i == 4) begin
        @(posedge PCLK); #1 PREADY = 1'b1;
      end
    end
    @(negedge PCLK);
    sb_compare("rd1");
    check("rd1_resp_busy", 64'({BUSY, PSEL}), 64'b10);

    // Write with slave error, next command accepted right after RESP
    @(posedge PCLK); #1;
    PSLVERR = 1'b1;
    set_cmd(0, 1'b1, 32'd4, 32'h55, 4'hF);
    REQ_VALID = 2'b01;
    wait_accept("err_accept", 2'b01);
    push_exp(0, 32'd0, 1'b1);
    @(posedge PCLK); #1;
    set_cmd(1, 1'b0, 32'd4, 32'd0, 4'd0);
    PRDATA = 32'h77;
    REQ_VALID = 2'b10;
    wait_rsp("err");
    @(posedge PCLK); #1 PSLVERR = 1'b0;
    @(negedge PCLK);
    check("err_next_accept", 64'(REQ_ACCEPT), 64'b10);
    push_exp(1, 32'h77, 1'b0);
    @(posedge PCLK); #1 REQ_VALID = 2'b00;
    wait_rsp("after_err");

`ifdef UART_APB_ARB_TIMEOUT_EN
    // Slave never ready: abort after TB_TIMEOUT wait cycles
    begin
      int acc;
      acc = 0;
      @(posedge PCLK); #1;
      PREADY = 1'b0; PRDATA = 32'h99;
      set_cmd(0, 1'b0, 32'd8, 32'd0, 4'd0);
      REQ_VALID = 2'b01;
      wait_accept("to_accept", 2'b01);
      push_exp(0, 32'd0, 1'b1);
      @(posedge PCLK); #1 REQ_VALID = 2'b00;
      @(negedge PCLK);
      for (int i = 0; i < 300; i++) begin
        @(negedge PCLK);
        if (PENABLE) acc++;
        else break;
      end
      check("to_wait_cycles", 64'(acc), 64'(TB_TIMEOUT));
      sb_compare("to");
      check("to_psel_off", 64'(PSEL), 64'd0);
      @(posedge PCLK); #1 PREADY = 1'b1;
    end
`endif

    // Reset during ACCESS aborts the transfer silently
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    set_cmd(0, 1'b0, 32'd0, 32'd0, 4'd0);
    REQ_VALID = 2'b01;
    wait_accept("abort_accept", 2'b01);
    @(posedge PCLK); #1 REQ_VALID = 2'b00;
    @(negedge PCLK);
    @(negedge PCLK);
    check("abort_in_access", 64'(PENABLE), 64'd1);
    #2 PRESET = 1'b1;
    #1 check("abort_apb_off", 64'({PSEL, PENABLE, BUSY}), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      check("abort_no_rsp", 64'(RSP_VALID), 64'd0);
    end
    @(posedge PCLK); #1;
    set_cmd(0, 1'b0, 32'd4, 32'd0, 4'd0);
    set_cmd(1, 1'b0, 32'd4, 32'd0, 4'd0);
    PRDATA = 32'hAB;
    REQ_VALID = 2'b11;
    wait_accept("post_rst_accept", 2'b01);
    push_exp(0, 32'hAB, 1'b0);
    @(posedge PCLK); #1 REQ_VALID = 2'b00;
    wait_rsp("post_rst");

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
